spi_master_param: RTL and testbench

Parametrised full-duplex SPI master. It is the next generation of the team's fixed 8-bit, mode-0, single-slave, transmit-only SPI master. It adds configurable word width, a runtime clock divider, all four CPOL/CPHA modes, MISO capture, multiple active-low chip selects and a valid/ready start handshake. It sits between register/control logic and the external SPI pins.

---
 rtl/spi_pkg.sv | 22 ++
 rtl/spi_master_param_if.sv | 60 ++++++
 rtl/spi_sclk_gen.sv | 73 +++++++
 rtl/spi_master_param.sv | 164 ++++++++++++++++
 tb/tb_spi_master_param.sv | 316 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/spi_pkg.sv
// Shared types and helpers for the parametrised SPI master (spi_master_param).
package spi_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StSetup,
    StXfer,
    StHold,
    StDone
  } spi_state_e;

  // {cpol, cpha} encodings of the four SPI modes
  localparam logic [1:0] MODE0 = 2'b00;
  localparam logic [1:0] MODE1 = 2'b01;
  localparam logic [1:0] MODE2 = 2'b10;
  localparam logic [1:0] MODE3 = 2'b11;

  function automatic int unsigned clog2_min1(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/spi_master_param_if.sv
// Control-side start handshake, transfer config and completion bus of spi_master_param.
// The lsb_first signal exists only when SPI_LSB_FIRST_EN is defined.
interface spi_master_param_if
  import spi_pkg::*;
#(
  parameter int unsigned DATA_W   = 8,
  parameter int unsigned DIV_W    = 8,
  parameter int unsigned NUM_CS   = 1,
  parameter int unsigned CS_IDX_W = clog2_min1(NUM_CS)
);

  logic                start_valid;
  logic                start_ready;
  logic [DATA_W-1:0]   tx_data;
  logic [CS_IDX_W-1:0] cs_sel;
  logic                cpol;
  logic                cpha;
  logic [DIV_W-1:0]    clk_div;
  logic [DATA_W-1:0]   rx_data;
  logic                rx_valid;
  logic                busy;
`ifdef SPI_LSB_FIRST_EN
  logic                lsb_first;
`endif

  // Requesting side (register/control logic)
  modport master (
`ifdef SPI_LSB_FIRST_EN
    output lsb_first,
`endif
    output start_valid,
    output tx_data,
    output cs_sel,
    output cpol,
    output cpha,
    output clk_div,
    input  start_ready,
    input  rx_data,
    input  rx_valid,
    input  busy
  );

  // SPI engine side
  modport slave (
`ifdef SPI_LSB_FIRST_EN
    input  lsb_first,
`endif
    input  start_valid,
    input  tx_data,
    input  cs_sel,
    input  cpol,
    input  cpha,
    input  clk_div,
    output start_ready,
    output rx_data,
    output rx_valid,
    output busy
  );

endinterface

// File: rtl/spi_sclk_gen.sv
// Half-period timer and SCLK edge generator: strobes one cycle before each visible
// SCLK transition, and also paces the SETUP/HOLD phases via tick.
module spi_sclk_gen
  import spi_pkg::*;
#(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned DIV_W  = 8,
  parameter int unsigned EDGE_W = $clog2(2 * DATA_W + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [DIV_W-1:0] half_period,
  input  logic             cpol,
  input  logic             active,
  input  logic             toggle_en,
  output logic             tick,
  output logic             leading_edge,
  output logic             trailing_edge,
  output logic             last_edge,
  output logic             sclk
);

  localparam logic [EDGE_W-1:0] LastEdge = EDGE_W'(2 * DATA_W - 1);

  logic [DIV_W-1:0]  h_q;
  logic [DIV_W-1:0]  cnt_q, cnt_d;
  logic [EDGE_W-1:0] edge_q, edge_d;
  logic              sclk_q, sclk_d;

  assign tick          = active & (cnt_q == '0);
  assign last_edge     = (edge_q == LastEdge);
  // Even edge indices move SCLK away from idle, odd ones return it
  assign leading_edge  = tick & toggle_en & ~edge_q[0];
  assign trailing_edge = tick & toggle_en & edge_q[0];
  assign sclk          = sclk_q;

  always_comb begin
    cnt_d  = cnt_q;
    edge_d = edge_q;
    sclk_d = sclk_q;
    if (load) begin
      cnt_d  = half_period - DIV_W'(1);
      edge_d = '0;
      sclk_d = cpol;
    end else if (tick) begin
      cnt_d = h_q - DIV_W'(1);
      if (toggle_en) begin
        edge_d = edge_q + EDGE_W'(1);
        sclk_d = ~sclk_q;
      end
    end else if (active) begin
      cnt_d = cnt_q - DIV_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      h_q    <= DIV_W'(1);
      cnt_q  <= '0;
      edge_q <= '0;
      sclk_q <= 1'b0;
    end else begin
      if (load) begin
        h_q <= half_period;
      end
      cnt_q  <= cnt_d;
      edge_q <= edge_d;
      sclk_q <= sclk_d;
    end
  end

endmodule

// File: rtl/spi_master_param.sv
// Parametrised full-duplex SPI master: FSM, shift registers and chip-select decode.
// Define SPI_LSB_FIRST_EN to add the per-transfer lsb_first option.
module spi_master_param
  import spi_pkg::*;
#(
  parameter int unsigned DATA_W   = 8,
  parameter int unsigned DIV_W    = 8,
  parameter int unsigned NUM_CS   = 1,
  parameter int unsigned CS_IDX_W = clog2_min1(NUM_CS)
) (
  input  logic              clk,
  input  logic              rst,
  spi_master_param_if.slave ctrl,
  input  logic              MISO,
  output logic              SCLK,
  output logic              MOSI,
  output logic [NUM_CS-1:0] SS
);

  spi_state_e state_q, state_d;

  logic              accept;
  logic              tick, leading_edge, trailing_edge, last_edge;
  logic              active, hold_done;
  logic              shift_en, sample_en;
  logic [DIV_W-1:0]  half_period;
  logic [NUM_CS-1:0] ss_sel;

  logic              cpha_q;
  logic              mosi_q;
  logic [NUM_CS-1:0] ss_q;
  logic [DATA_W-1:0] tx_sh_q, rx_sh_q, rx_data_q;
  logic              rx_valid_q;

  logic              first_bit, next_bit;
  logic [DATA_W-1:0] load_word, tx_shifted, rx_shifted;

`ifdef SPI_LSB_FIRST_EN
  logic lsb_q, lsb_in;
  assign lsb_in = ctrl.lsb_first;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lsb_q <= 1'b0;
    end else if (accept) begin
      lsb_q <= lsb_in;
    end
  end
`else
  logic lsb_q, lsb_in;
  assign lsb_in = 1'b0;
  assign lsb_q  = 1'b0;
`endif

  assign ctrl.start_ready = (state_q == StIdle) & ~rst;
  assign ctrl.busy        = (state_q != StIdle);
  assign ctrl.rx_data     = rx_data_q;
  assign ctrl.rx_valid    = rx_valid_q;
  assign accept           = ctrl.start_valid & ctrl.start_ready;

  assign half_period = (ctrl.clk_div == '0) ? DIV_W'(1) : ctrl.clk_div;
  assign active      = (state_q == StSetup) | (state_q == StXfer) | (state_q == StHold);
  assign hold_done   = (state_q == StHold) & tick;

  // cpha=0 keeps the final bit on the line through the last trailing edge
  assign shift_en  = cpha_q ? leading_edge : (trailing_edge & ~last_edge);
  assign sample_en = cpha_q ? trailing_edge : leading_edge;

  spi_sclk_gen #(
    .DATA_W (DATA_W),
    .DIV_W  (DIV_W)
  ) u_sclk_gen (
    .clk           (clk),
    .rst           (rst),
    .load          (accept),
    .half_period   (half_period),
    .cpol          (ctrl.cpol),
    .active        (active),
    .toggle_en     (state_q == StXfer),
    .tick          (tick),
    .leading_edge  (leading_edge),
    .trailing_edge (trailing_edge),
    .last_edge     (last_edge),
    .sclk          (SCLK)
  );

  always_comb begin
    ss_sel = '1;
    for (int i = 0; i < NUM_CS; i++) begin
      ss_sel[i] = (ctrl.cs_sel != CS_IDX_W'(i));
    end
  end

  always_comb begin
    first_bit  = lsb_in ? ctrl.tx_data[0] : ctrl.tx_data[DATA_W-1];
    load_word  = lsb_in ? (ctrl.tx_data >> 1) : (ctrl.tx_data << 1);
    next_bit   = lsb_q ? tx_sh_q[0] : tx_sh_q[DATA_W-1];
    tx_shifted = lsb_q ? (tx_sh_q >> 1) : (tx_sh_q << 1);
    // LSB-first words enter at the top so the result lands in natural order
    rx_shifted = lsb_q ? {MISO, rx_sh_q[DATA_W-1:1]} : {rx_sh_q[DATA_W-2:0], MISO};
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (accept) state_d = StSetup;
      StSetup: if (tick) state_d = StXfer;
      StXfer:  if (tick && last_edge) state_d = StHold;
      StHold:  if (tick) state_d = StDone;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cpha_q     <= 1'b0;
      mosi_q     <= 1'b0;
      ss_q       <= '1;
      tx_sh_q    <= '0;
      rx_sh_q    <= '0;
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
    end else begin
      rx_valid_q <= hold_done;
      if (accept) begin
        cpha_q  <= ctrl.cpha;
        ss_q    <= ss_sel;
        rx_sh_q <= '0;
        if (ctrl.cpha) begin
          // First bit goes out on the first leading edge instead
          tx_sh_q <= ctrl.tx_data;
          mosi_q  <= 1'b0;
        end else begin
          tx_sh_q <= load_word;
          mosi_q  <= first_bit;
        end
      end else begin
        if (shift_en) begin
          mosi_q  <= next_bit;
          tx_sh_q <= tx_shifted;
        end
        if (sample_en) begin
          rx_sh_q <= rx_shifted;
        end
        if (hold_done) begin
          ss_q      <= '1;
          rx_data_q <= rx_sh_q;
        end
      end
    end
  end

  assign MOSI = mosi_q;
  assign SS   = ss_q;

endmodule

// File: tb/tb_spi_master_param.sv
// Self-checking bench for spi_master_param: directed and random transfers against a
// behavioural SPI slave and counters derived from the transfer timing rules.
module tb_spi_master_param;
  import spi_pkg::*;

  localparam int unsigned DW   = 8;
  localparam int unsigned NCS  = 4;
  localparam int unsigned CSW  = 3;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           miso, sclk, mosi;
  logic [NCS-1:0] ss;

  always #5 clk = ~clk;

  spi_master_param_if #(.DATA_W(DW), .DIV_W(8), .NUM_CS(NCS), .CS_IDX_W(CSW)) bus ();

  spi_master_param #(
    .DATA_W   (DW),
    .DIV_W    (8),
    .NUM_CS   (NCS),
    .CS_IDX_W (CSW)
  ) dut (
    .clk  (clk),
    .rst  (rst),
    .ctrl (bus),
    .MISO (miso),
    .SCLK (sclk),
    .MOSI (mosi),
    .SS   (ss)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic wbit(input logic [DW-1:0] w, input int k, input bit lsb);
    if (k >= int'(DW)) return 1'b0;
    return lsb ? w[k] : w[DW-1-k];
  endfunction

  // Behavioural slave: reacts to visible SCLK transitions of the selected bus.
  logic [DW-1:0] slave_word = '0;
  logic [DW-1:0] s_rx = '0;
  logic [DW-1:0] cap_q[$];
  int            s_out = 0;
  int            glitches = 0;
  logic          s_sel_prev = 1'b0, s_sclk_prev = 1'b0, s_mosi_prev = 1'b0;
  logic          slave_miso = 1'b0;
  bit            loopback = 0, cur_cpol = 0, cur_cpha = 0, slave_lsb = 0;

  assign miso = loopback ? mosi : slave_miso;

  always @(negedge clk) begin
    logic sel, lead;
    sel = (ss != '1);
    if (sel && !s_sel_prev) begin
      s_rx  = '0;
      s_out = 0;
      if (!cur_cpha) begin
        slave_miso = wbit(slave_word, 0, slave_lsb);
        s_out = 1;
      end
    end else if (sel && sclk !== s_sclk_prev) begin
      lead = (sclk !== cur_cpol);
      if (lead != cur_cpha) begin
        if (mosi !== s_mosi_prev) glitches++;
        s_rx = slave_lsb ? {mosi, s_rx[DW-1:1]} : {s_rx[DW-2:0], mosi};
      end else begin
        slave_miso = wbit(slave_word, s_out, slave_lsb);
        s_out++;
      end
    end
    if (!sel) begin
      if (s_sel_prev) cap_q.push_back(s_rx);
      slave_miso = 1'b0;
    end
    s_sel_prev  = sel;
    s_sclk_prev = sclk;
    s_mosi_prev = mosi;
  end

  // Observation counters
  int            cyc = 0, busy_cyc = 0, edges = 0, rises = 0, ss_run = 0;
  logic [NCS-1:0] ss_low_seen = '0;
  logic [DW-1:0] rx_q[$];
  int            rxv_t[$];
  int            gaps[$];
  logic [5:0]    trace[$];
  logic          sclk_m = 1'b0, busy_m = 1'b0;

  always @(negedge clk) begin
    cyc++;
    if (bus.busy === 1'b1) begin
      busy_cyc++;
      trace.push_back({sclk, mosi, ss});
      if (busy_m && sclk !== sclk_m) begin
        edges++;
        if (sclk) rises++;
      end
    end
    if (bus.rx_valid === 1'b1) begin
      rx_q.push_back(bus.rx_data);
      rxv_t.push_back(cyc);
    end
    ss_low_seen = ss_low_seen | ~ss;
    if (&ss) begin
      ss_run++;
    end else begin
      if (ss_run > 0) gaps.push_back(ss_run);
      ss_run = 0;
    end
    sclk_m = sclk;
    busy_m = bus.busy;
  end

  task automatic clear_mon();
    busy_cyc = 0; edges = 0; rises = 0; glitches = 0; ss_low_seen = '0;
    rx_q.delete(); rxv_t.delete(); gaps.delete(); trace.delete(); cap_q.delete();
  endtask

  task automatic wait_idle(output bit ok);
    ok = 0;
    for (int i = 0; i < 4000; i++) begin
      @(posedge clk); #1;
      if (bus.busy === 1'b0) begin
        ok = 1;
        break;
      end
    end
  endtask

  task automatic run(input string t, input logic [DW-1:0] tx, input int cs,
                     input logic [1:0] mode, input int div, input logic [DW-1:0] sw,
                     input bit loop, input bit lsb);
    int            h;
    bit            ok;
    logic [DW-1:0] exp_rx;
    logic [NCS-1:0] exp_ss;
    h      = (div == 0) ? 1 : div;
    exp_rx = loop ? tx : ((cs < int'(NCS)) ? sw : '0);
    exp_ss = (cs < int'(NCS)) ? NCS'(1 << cs) : '0;
    clear_mon();
    slave_word = sw; loopback = loop; cur_cpol = mode[1]; cur_cpha = mode[0]; slave_lsb = lsb;
    bus.tx_data = tx; bus.cs_sel = CSW'(cs); bus.cpol = mode[1]; bus.cpha = mode[0];
    bus.clk_div = 8'(div);
`ifdef SPI_LSB_FIRST_EN
    bus.lsb_first = lsb;
`endif
    bus.start_valid = 1'b1;
    @(posedge clk); #1;
    // Scramble inputs after accept; the transfer must use the latched values
    bus.start_valid = 1'b0;
    bus.tx_data = DW'($urandom); bus.cs_sel = CSW'($urandom); bus.cpol = ~mode[1];
    bus.cpha = ~mode[0]; bus.clk_div = 8'($urandom_range(0, 3));
`ifdef SPI_LSB_FIRST_EN
    bus.lsb_first = ~lsb;
`endif
    chk({t, ".busy_on"}, bus.busy, 1);
    chk({t, ".sclk_setup"}, sclk, mode[1]);
    if (!mode[0]) chk({t, ".first_mosi"}, mosi, wbit(tx, 0, lsb));
    wait_idle(ok);
    chk({t, ".done"}, ok, 1);
    chk({t, ".rxv_cnt"}, rx_q.size(), 1);
    chk({t, ".rx"}, (rx_q.size() == 1) ? rx_q[0] : 'x, exp_rx);
    chk({t, ".rx_held"}, bus.rx_data, exp_rx);
    chk({t, ".busy_len"}, busy_cyc, (2 * DW + 2) * h + 1);
    chk({t, ".edges"}, edges, 2 * DW);
    chk({t, ".sclk_idle"}, sclk, mode[1]);
    chk({t, ".ss_seen"}, ss_low_seen, exp_ss);
    chk({t, ".ss_idle"}, ss, {NCS{1'b1}});
    chk({t, ".cap_cnt"}, cap_q.size(), (cs < int'(NCS)) ? 1 : 0);
    if (cs < int'(NCS)) chk({t, ".cap"}, (cap_q.size() == 1) ? cap_q[0] : 'x, tx);
    chk({t, ".mosi_stable"}, glitches, 0);
  endtask

  initial begin
    bit         ok;
    bit         lsb_r;
    int         n;
    logic [5:0] tr0[$];

    bus.start_valid = 1'b0; bus.tx_data = '0; bus.cs_sel = '0; bus.cpol = 1'b0;
    bus.cpha = 1'b0; bus.clk_div = '0;
`ifdef SPI_LSB_FIRST_EN
    bus.lsb_first = 1'b0;
`endif
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst.ss", ss, {NCS{1'b1}});
    chk("rst.sclk", sclk, 0);
    chk("rst.mosi", mosi, 0);
    chk("rst.rx_data", bus.rx_data, 0);
    chk("rst.rx_valid", bus.rx_valid, 0);
    chk("rst.busy", bus.busy, 0);
    chk("rst.ready", bus.start_ready, 0);
    rst = 1'b0;
    #1;
    chk("idle.ready", bus.start_ready, 1);
    @(posedge clk); #1;

    // Loopback, mode 0, H=2
    run("t1", 8'hA5, 0, MODE0, 2, 8'h00, 1, 0);
    chk("t1.rises", rises, DW);

    // All four modes against a slave returning 0xC3
    for (int m = 0; m < 4; m++) run($sformatf("t2.m%0d", m), 8'h3C, 0, 2'(m), 2, 8'hC3, 0, 0);

    // Chip-select decode, including an out-of-range index
    run("t3a", 8'h96, 2, MODE0, 2, 8'h69, 0, 0);
    run("t3b", 8'h96, 5, MODE0, 2, 8'h69, 0, 0);

    // clk_div 0 behaves as 1
    run("t4a", 8'hFF, 1, MODE0, 0, 8'h81, 0, 0);
    tr0 = trace;
    run("t4b", 8'hFF, 1, MODE0, 1, 8'h81, 0, 0);
    ok = (tr0.size() == trace.size());
    foreach (tr0[i]) if (i < trace.size() && tr0[i] !== trace[i]) ok = 0;
    chk("t4.same_wave", ok, 1);

    // Reset in the middle of XFER
    clear_mon();
    slave_word = 8'h3D; loopback = 0; cur_cpol = 0; cur_cpha = 0; slave_lsb = 0;
    bus.tx_data = 8'hE7; bus.cs_sel = 3'd1; bus.cpol = 1'b0; bus.cpha = 1'b0; bus.clk_div = 8'd2;
`ifdef SPI_LSB_FIRST_EN
    bus.lsb_first = 1'b0;
`endif
    bus.start_valid = 1'b1;
    @(posedge clk); #1;
    bus.start_valid = 1'b0;
    ok = 0;
    for (int i = 0; i < 500; i++) begin
      @(posedge clk); #1;
      if (edges >= 7) begin
        ok = 1;
        break;
      end
    end
    chk("t5.reach_bit3", ok, 1);
    rst = 1'b1;
    #1;
    chk("t5.ss", ss, {NCS{1'b1}});
    chk("t5.sclk", sclk, 0);
    chk("t5.busy", bus.busy, 0);
    chk("t5.ready", bus.start_ready, 0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    chk("t5.no_rxv", rx_q.size(), 0);
    run("t5b", 8'h5A, 1, MODE0, 2, 8'($urandom), 0, 0);

    // start_valid held high across two back-to-back transfers
    clear_mon();
    slave_word = '0; loopback = 1; cur_cpol = 0; cur_cpha = 0; slave_lsb = 0;
    bus.tx_data = 8'h12; bus.cs_sel = 3'd0; bus.cpol = 1'b0; bus.cpha = 1'b0; bus.clk_div = 8'd2;
    bus.start_valid = 1'b1;
    @(posedge clk); #1;
    bus.tx_data = 8'h34;
    n = 0;
    ok = 0;
    for (int i = 0; i < 400; i++) begin
      @(posedge clk); #1;
      if (bus.rx_valid === 1'b1) begin
        n++;
        if (n == 2) begin
          bus.start_valid = 1'b0;
          ok = 1;
          break;
        end
      end
    end
    chk("t6.two_done", ok, 1);
    wait_idle(ok);
    chk("t6.idle", ok, 1);
    chk("t6.rxv_cnt", rx_q.size(), 2);
    chk("t6.rx0", (rx_q.size() == 2) ? rx_q[0] : 'x, 8'h12);
    chk("t6.rx1", (rx_q.size() == 2) ? rx_q[1] : 'x, 8'h34);
    // 37 busy cycles plus the accepting IDLE cycle separate the pulses
    chk("t6.rxv_spacing", (rxv_t.size() == 2) ? rxv_t[1] - rxv_t[0] : -1, 37 + 1);
    chk("t6.ss_gap", (gaps.size() > 0) ? gaps[gaps.size() - 1] : -1, 2);

    // Bit order of the first MOSI bit
`ifdef SPI_LSB_FIRST_EN
    run("t6.lsb", 8'h01, 3, MODE0, 2, 8'hB4, 0, 1);
    run("t6.lsb_m3", 8'hC6, 3, MODE3, 1, 8'h2D, 0, 1);
`else
    run("t6.msb", 8'h01, 3, MODE0, 2, 8'hB4, 0, 0);
`endif

    // Random transfers
    for (int i = 0; i < 10; i++) begin
`ifdef SPI_LSB_FIRST_EN
      lsb_r = 1'($urandom);
`else
      lsb_r = 0;
`endif
      run($sformatf("rnd%0d", i), 8'($urandom), int'($urandom_range(0, 5)), 2'($urandom),
          int'($urandom_range(0, 3)), 8'($urandom), 0, lsb_r);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
